tcam_route_lookup: RTL and testbench

- Parametrised, behavioural TCAM routing table. Successor to the hard-macro 16x8 CAM lookup.
- Stores N ternary key entries. Each entry carries a destination ID and a weight.
- Serves a pipelined lookup stream with valid/ready backpressure, lowest-index priority, per-entry invalidate and global flush.
- Sits between the packet ingress decoder and the axon/weight fetch stage.

---
 rtl/tcam_route_lookup.sv | 161 ++++++++++++++++
 tb/tb_tcam_route_lookup.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcam_route_lookup.sv
// Behavioural ternary-CAM routing table with a two-stage lookup pipeline.
// S1 registers the per-entry match vector of an accepted key. S2 priority-encodes
// that vector (lowest index wins), fetches dst/wgt and holds the result until
// it is consumed.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 clear every entry valid bit
//   wr_*                  entry write (addr, valid, key, care mask, dst, weight)
//   lk_valid/ready/key    lookup request handshake
//   res_valid/ready       result handshake
//   res_hit/idx/dst/wgt   lookup result (all zero on miss)
//   hit_cnt, miss_cnt     saturating delivered-result statistics
module tcam_route_lookup #(
    parameter int unsigned KEY_W   = 8,
    parameter int unsigned DST_W   = 4,
    parameter int unsigned WGT_W   = 4,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned ADDR_W  = $clog2(ENTRIES),
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_vld,
    input  logic [KEY_W-1:0]  wr_key,
    input  logic [KEY_W-1:0]  wr_mask,
    input  logic [DST_W-1:0]  wr_dst,
    input  logic [WGT_W-1:0]  wr_wgt,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [KEY_W-1:0]  lk_key,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_hit,
    output logic [ADDR_W-1:0] res_idx,
    output logic [DST_W-1:0]  res_dst,
    output logic [WGT_W-1:0]  res_wgt,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    logic [KEY_W-1:0]   key_tbl  [ENTRIES];
    logic [KEY_W-1:0]   mask_tbl [ENTRIES];
    logic [DST_W-1:0]   dst_tbl  [ENTRIES];
    logic [WGT_W-1:0]   wgt_tbl  [ENTRIES];
    logic [ENTRIES-1:0] vld;

    logic               wr_in_range;
    logic [ENTRIES-1:0] match;
    logic               stall;
    logic               s1_valid;
    logic [ENTRIES-1:0] s1_vec;
    logic               enc_hit;
    logic [ADDR_W-1:0]  enc_idx;

    // Extra top bit keeps the compare meaningful when ENTRIES is a power of two.
    assign wr_in_range = ({1'b0, wr_addr} < (ADDR_W+1)'(ENTRIES));

    assign stall    = res_valid && !res_ready;
    assign lk_ready = !stall;

    // Entry payload: no reset, only the valid bits define table state.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            key_tbl[wr_addr]  <= wr_key;
            mask_tbl[wr_addr] <= wr_mask;
            dst_tbl[wr_addr]  <= wr_dst;
            wgt_tbl[wr_addr]  <= wr_wgt;
        end
    end

    // Valid bits: a write on the flush edge overrides the flush for its own entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            if (flush) begin
                vld <= '0;
            end
            if (wr_en && wr_in_range) begin
                vld[wr_addr] <= wr_vld;
            end
        end
    end

    // Ternary compare against the pre-edge table contents.
    always_comb begin
        match = '0;
        for (int i = 0; i < int'(ENTRIES); i++) begin
            match[i] = vld[i] && (((lk_key ^ key_tbl[i]) & mask_tbl[i]) == '0);
        end
    end

    // S1: match vector of the accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_vec   <= '0;
        end else if (!stall) begin
            s1_valid <= lk_valid;
            s1_vec   <= lk_valid ? match : '0;
        end
    end

    // Descending scan so the lowest matching index is the last one assigned.
    always_comb begin
        enc_hit = 1'b0;
        enc_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (s1_vec[i]) begin
                enc_hit = 1'b1;
                enc_idx = ADDR_W'(i);
            end
        end
    end

    // S2: output register, held while the consumer back-pressures.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_idx   <= '0;
            res_dst   <= '0;
            res_wgt   <= '0;
        end else if (!stall) begin
            res_valid <= s1_valid;
            if (s1_valid && enc_hit) begin
                res_hit <= 1'b1;
                res_idx <= enc_idx;
                res_dst <= dst_tbl[enc_idx];
                res_wgt <= wgt_tbl[enc_idx];
            end else begin
                res_hit <= 1'b0;
                res_idx <= '0;
                res_dst <= '0;
                res_wgt <= '0;
            end
        end
    end

    // Saturating statistics on delivered results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (res_valid && res_ready) begin
            if (res_hit) begin
                if (hit_cnt != '1) begin
                    hit_cnt <= hit_cnt + CNT_W'(1);
                end
            end else begin
                if (miss_cnt != '1) begin
                    miss_cnt <= miss_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_tcam_route_lookup.sv
// Self-checking bench for tcam_route_lookup: scoreboard of expected results,
// table-driven lookup vectors and hand-written stall/flush/reset sequences.
// A second instance built with CNT_W=2 exercises counter saturation.
module tb_tcam_route_lookup;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
        logic [3:0] dst;
        logic [3:0] wgt;
    } res_t;

    typedef struct {
        logic [7:0] key;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       wr_vld;
    logic [7:0] wr_key;
    logic [7:0] wr_mask;
    logic [3:0] wr_dst;
    logic [3:0] wr_wgt;
    logic       lk_valid;
    logic       lk_ready;
    logic [7:0] lk_key;
    logic       res_valid;
    logic       res_ready;
    logic       res_hit;
    logic [3:0] res_idx;
    logic [3:0] res_dst;
    logic [3:0] res_wgt;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    // Saturation instance signals
    logic       s_lk_valid;
    logic       s_lk_ready;
    logic       s_res_valid;
    logic       s_res_hit;
    logic [3:0] s_res_idx;
    logic [3:0] s_res_dst;
    logic [3:0] s_res_wgt;
    logic [1:0] s_hit_cnt;
    logic [1:0] s_miss_cnt;

    int errors = 0;
    int checks = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    res_t exp_q[$];
    res_t mon_e;
    bit   vec_done;

    // Reference table
    logic [7:0] m_key  [16];
    logic [7:0] m_mask [16];
    logic [3:0] m_dst  [16];
    logic [3:0] m_wgt  [16];
    logic [15:0] m_vld = '0;

    tcam_route_lookup dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_vld(wr_vld), .wr_key(wr_key),
        .wr_mask(wr_mask), .wr_dst(wr_dst), .wr_wgt(wr_wgt),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
        .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
        .res_idx(res_idx), .res_dst(res_dst), .res_wgt(res_wgt),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    tcam_route_lookup #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .wr_en(1'b0), .wr_addr(4'd0), .wr_vld(1'b0), .wr_key(8'd0),
        .wr_mask(8'd0), .wr_dst(4'd0), .wr_wgt(4'd0),
        .lk_valid(s_lk_valid), .lk_ready(s_lk_ready), .lk_key(8'h3C),
        .res_valid(s_res_valid), .res_ready(1'b1), .res_hit(s_res_hit),
        .res_idx(s_res_idx), .res_dst(s_res_dst), .res_wgt(s_res_wgt),
        .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare each delivered result with the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got idx %0d hit %0d, expected none", res_idx, res_hit);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_hit", 32'(res_hit), 32'(mon_e.hit));
                chk("res_idx", 32'(res_idx), 32'(mon_e.idx));
                chk("res_dst", 32'(res_dst), 32'(mon_e.dst));
                chk("res_wgt", 32'(res_wgt), 32'(mon_e.wgt));
                if (mon_e.hit) exp_hits++;
                else           exp_misses++;
            end
        end
    end

    function automatic res_t predict(input logic [7:0] k);
        res_t r;
        r = '0;
        for (int i = 15; i >= 0; i--) begin
            if (m_vld[i] && (((k ^ m_key[i]) & m_mask[i]) == 8'h00)) begin
                r.hit = 1'b1;
                r.idx = 4'(i);
                r.dst = m_dst[i];
                r.wgt = m_wgt[i];
            end
        end
        return r;
    endfunction

    task automatic write_entry(input logic [3:0] a, input logic v, input logic [7:0] k,
                               input logic [7:0] m, input logic [3:0] d, input logic [3:0] w);
        wr_en = 1'b1; wr_addr = a; wr_vld = v; wr_key = k; wr_mask = m; wr_dst = d; wr_wgt = w;
        @(posedge clk); #1;
        wr_en = 1'b0;
        m_key[a] = k; m_mask[a] = m; m_dst[a] = d; m_wgt[a] = w; m_vld[a] = v;
    endtask

    // Present one request until accepted; expectation is queued on acceptance.
    task automatic lookup(input logic [7:0] k, input logic fl, input res_t e);
        bit acc;
        acc = 1'b0;
        lk_valid = 1'b1;
        lk_key   = k;
        flush    = fl;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            acc = lk_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        lk_valid = 1'b0;
        flush    = 1'b0;
        if (acc) exp_q.push_back(e);
        else chk("accept_timeout", 32'(acc), 32'(1));
    endtask

    task automatic drain();
        for (int n = 0; n < 200; n++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vecs[7];
        vecs[0] = '{key: 8'hA7, exp: '{hit: 1'b1, idx: 4'd3,  dst: 4'd5, wgt: 4'd9}};
        vecs[1] = '{key: 8'h55, exp: '{hit: 1'b1, idx: 4'd7,  dst: 4'd6, wgt: 4'd4}};
        vecs[2] = '{key: 8'h1C, exp: '{hit: 1'b1, idx: 4'd10, dst: 4'hE, wgt: 4'd1}};
        vecs[3] = '{key: 8'hAC, exp: '{hit: 1'b1, idx: 4'd3,  dst: 4'd5, wgt: 4'd9}};
        vecs[4] = '{key: 8'h00, exp: '{hit: 1'b1, idx: 4'd12, dst: 4'd2, wgt: 4'd3}};
        vecs[5] = '{key: 8'hFF, exp: '{hit: 1'b1, idx: 4'd12, dst: 4'd2, wgt: 4'd3}};
        vecs[6] = '{key: 8'h5C, exp: '{hit: 1'b1, idx: 4'd10, dst: 4'hE, wgt: 4'd1}};

        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_vld = 1'b0;
        wr_key = '0; wr_mask = '0; wr_dst = '0; wr_wgt = '0;
        lk_valid = 1'b0; lk_key = '0; res_ready = 1'b1; s_lk_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst_res_valid", 32'(res_valid), 32'(0));
        chk("rst_res_hit",   32'(res_hit),   32'(0));
        chk("rst_res_idx",   32'(res_idx),   32'(0));
        chk("rst_hit_cnt",   32'(hit_cnt),   32'(0));
        chk("rst_miss_cnt",  32'(miss_cnt),  32'(0));
        chk("rst_lk_ready",  32'(lk_ready),  32'(1));

        // Empty table miss
        lookup(8'h12, 1'b0, '{hit: 1'b0, idx: 4'd0, dst: 4'd0, wgt: 4'd0});
        drain();
        chk("miss_cnt_empty", 32'(miss_cnt), 32'(1));

        // Single hit with latency check
        write_entry(4'd3, 1'b1, 8'hA0, 8'hF0, 4'd5, 4'd9);
        lookup(8'hA7, 1'b0, '{hit: 1'b1, idx: 4'd3, dst: 4'd5, wgt: 4'd9});
        chk("lat_s1_only", 32'(res_valid), 32'(0));
        @(posedge clk); #1;
        chk("lat_s2_valid", 32'(res_valid), 32'(1));
        drain();
        chk("hit_cnt_first", 32'(hit_cnt), 32'(1));

        // Priority and invalidate
        write_entry(4'd2, 1'b1, 8'h55, 8'hFF, 4'd1, 4'd8);
        write_entry(4'd7, 1'b1, 8'h55, 8'hFF, 4'd6, 4'd4);
        lookup(8'h55, 1'b0, '{hit: 1'b1, idx: 4'd2, dst: 4'd1, wgt: 4'd8});
        drain();
        write_entry(4'd2, 1'b0, 8'h55, 8'hFF, 4'd1, 4'd8);
        lookup(8'h55, 1'b0, '{hit: 1'b1, idx: 4'd7, dst: 4'd6, wgt: 4'd4});
        drain();

        // Table-driven vectors under random back-pressure
        write_entry(4'd10, 1'b1, 8'h0C, 8'h0F, 4'hE, 4'd1);
        write_entry(4'd12, 1'b1, 8'h00, 8'h00, 4'd2, 4'd3);
        vec_done = 1'b0;
        fork
            begin
                for (int v = 0; v < 7; v++) lookup(vecs[v].key, 1'b0, vecs[v].exp);
                vec_done = 1'b1;
            end
            begin
                while (!vec_done) begin
                    @(posedge clk); #1;
                    res_ready = 1'($urandom_range(0, 1));
                end
                res_ready = 1'b1;
            end
        join
        drain();
        chk("hit_cnt_mid",  32'(hit_cnt),  32'(exp_hits));
        chk("miss_cnt_mid", 32'(miss_cnt), 32'(exp_misses));

        // Back-to-back lookups with a 3-cycle stall
        res_ready = 1'b0;
        fork
            begin
                lookup(8'hA1, 1'b0, predict(8'hA1));
                lookup(8'h55, 1'b0, predict(8'h55));
                lookup(8'h00, 1'b0, predict(8'h00));
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                chk("stall_lk_ready", 32'(lk_ready),  32'(0));
                chk("stall_valid",    32'(res_valid), 32'(1));
                chk("stall_idx",      32'(res_idx),   32'(3));
                @(posedge clk); #1;
                chk("stall_lk_ready2", 32'(lk_ready), 32'(0));
                chk("stall_dst_held",  32'(res_dst),  32'(5));
                chk("stall_wgt_held",  32'(res_wgt),  32'(9));
                res_ready = 1'b1;
            end
        join
        drain();
        chk("hit_cnt_stall", 32'(hit_cnt), 32'(exp_hits));

        // Flush on the accept edge: that lookup still sees the old table
        lookup(8'hA7, 1'b1, predict(8'hA7));
        m_vld = '0;
        lookup(8'hA7, 1'b0, predict(8'hA7));
        drain();
        chk("miss_cnt_flush", 32'(miss_cnt), 32'(exp_misses));
        chk("hit_cnt_flush",  32'(hit_cnt),  32'(exp_hits));

        // Saturating counter on the CNT_W=2 instance
        s_lk_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 s_lk_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("sat_miss_cnt", 32'(s_miss_cnt), 32'(3));
        chk("sat_hit_cnt",  32'(s_hit_cnt),  32'(0));

        // Reset with two lookups in flight
        res_ready = 1'b0;
        lookup(8'h12, 1'b0, predict(8'h12));
        lookup(8'h34, 1'b0, predict(8'h34));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst2_res_valid", 32'(res_valid), 32'(0));
        chk("rst2_hit_cnt",   32'(hit_cnt),   32'(0));
        chk("rst2_miss_cnt",  32'(miss_cnt),  32'(0));
        chk("rst2_lk_ready",  32'(lk_ready),  32'(1));
        exp_q.delete();
        rst_n = 1'b1;
        res_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("rst2_no_result", 32'(res_valid), 32'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
